// File: rtl/mem_bist_ctrl.sv
// Memory BIST initiator: writes an LFSR pattern to every word, reads it back, counts mismatches.
// Latency: done is asserted 2*DEPTH+RD_LAT cycles after the start-sampling edge (DONE lasts one cycle).
// Backpressure: none; the memory is assumed ready every cycle, and start is ignored unless IDLE.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start                     begin a test run (sampled only in IDLE)
//   addr, wdata, wrbar        memory request (wrbar=1 write, 0 read)
//   rdata                     memory read data, valid RD_LAT cycles after a read address
//   busy, done, pass          run status; done is a one-cycle pulse, pass is held
//   err_count, first_fail_addr  mismatch count and lowest failing address
module mem_bist_ctrl #(
  parameter int                WIDTH  = 32,
  parameter int                DEPTH  = 256,
  parameter int                ADDR   = 8,
  parameter int                RD_LAT = 1,
  parameter logic [WIDTH-1:0]  POLY   = 32'h80200003,
  parameter logic [WIDTH-1:0]  SEED   = 32'h00000001
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR-1:0]   addr,
  output logic [WIDTH-1:0]  wdata,
  output logic              wrbar,
  input  logic [WIDTH-1:0]  rdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR:0]     err_count,
  output logic [ADDR-1:0]   first_fail_addr
);

  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [WIDTH-1:0] SEED_EFF   = (SEED == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : SEED;
  localparam int               DW         = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [DW-1:0]    DRAIN_LAST = DW'(RD_LAT - 1);
  localparam logic [ADDR-1:0]  LAST       = ADDR'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [ADDR-1:0]  cnt;
  logic [DW-1:0]    drain_cnt;
  logic [WIDTH-1:0] lfsr;
  logic             rd_issue;

  // Expected word and address travel alongside each read so they meet rdata.
  logic [RD_LAT-1:0] pipe_vld;
  logic [WIDTH-1:0]  pipe_exp [RD_LAT];
  logic [ADDR-1:0]   pipe_adr [RD_LAT];
  logic              miss;

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] l);
    return {l[WIDTH-2:0], 1'b0} ^ (l[WIDTH-1] ? POLY : '0);
  endfunction

  assign miss = pipe_vld[RD_LAT-1] && (rdata != pipe_exp[RD_LAT-1]);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Bus outputs decode straight from the registered state and counter.
  always_comb begin
    state_nxt = state;
    addr      = '0;
    wdata     = '0;
    wrbar     = 1'b0;
    done      = 1'b0;
    rd_issue  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        wrbar = 1'b1;
        addr  = cnt;
        wdata = lfsr;
        if (cnt == LAST) state_nxt = S_READ;
      end
      S_READ: begin
        addr     = cnt;
        rd_issue = 1'b1;
        if (cnt == LAST) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_cnt == DRAIN_LAST) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt             <= '0;
      drain_cnt       <= '0;
      lfsr            <= SEED_EFF;
      busy            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_fail_addr <= '0;
      pipe_vld        <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_exp[i] <= '0;
        pipe_adr[i] <= '0;
      end
    end else begin
      pipe_vld[0] <= rd_issue;
      pipe_exp[0] <= lfsr;
      pipe_adr[0] <= cnt;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_exp[i] <= pipe_exp[i-1];
        pipe_adr[i] <= pipe_adr[i-1];
      end

      // Reads return in address order, so the first miss is the lowest address.
      if (miss) begin
        err_count <= err_count + (ADDR+1)'(1);
        if (err_count == '0) first_fail_addr <= pipe_adr[RD_LAT-1];
      end

      case (state)
        S_IDLE: begin
          cnt       <= '0;
          drain_cnt <= '0;
          if (start) begin
            busy      <= 1'b1;
            err_count <= '0;
            pass      <= 1'b0;
            lfsr      <= SEED_EFF;
          end
        end
        S_WRITE, S_READ: begin
          // Reloading the seed at the end of WRITE regenerates the same stream for READ.
          if (cnt == LAST) begin
            cnt  <= '0;
            lfsr <= SEED_EFF;
          end else begin
            cnt  <= cnt + ADDR'(1);
            lfsr <= lfsr_step(lfsr);
          end
        end
        S_DRAIN: drain_cnt <= drain_cnt + DW'(1);
        S_DONE: begin
          busy <= 1'b0;
          pass <= (err_count == '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bist_ctrl.sv
module tb_mem_bist_ctrl;
  localparam int          W    = 32;
  localparam int          D    = 256;
  localparam int          A    = 8;
  localparam int          L    = 1;
  localparam logic [31:0] POLY = 32'h80200003;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start_a, start_b;
  logic [A-1:0]  addr_a, addr_b, ffa_a, ffa_b;
  logic [W-1:0]  wdata_a, wdata_b, rdata_a, rdata_b;
  logic          wrbar_a, wrbar_b, busy_a, busy_b, done_a, done_b, pass_a, pass_b;
  logic [A:0]    err_a, err_b;

  mem_bist_ctrl #(.WIDTH(W), .DEPTH(D), .ADDR(A), .RD_LAT(L), .POLY(POLY), .SEED(32'h1)) dut (
    .clk(clk), .rst(rst), .start(start_a), .addr(addr_a), .wdata(wdata_a), .wrbar(wrbar_a),
    .rdata(rdata_a), .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
    .first_fail_addr(ffa_a));

  mem_bist_ctrl #(.WIDTH(W), .DEPTH(D), .ADDR(A), .RD_LAT(L), .POLY(POLY), .SEED(32'h0)) dut_s0 (
    .clk(clk), .rst(rst), .start(start_b), .addr(addr_b), .wdata(wdata_b), .wrbar(wrbar_b),
    .rdata(rdata_b), .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
    .first_fail_addr(ffa_b));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit chk_en  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory models: single-port, one-cycle read latency; flip[] corrupts words on read.
  logic [W-1:0] mem_a [D];
  logic [W-1:0] mem_b [D];
  logic [W-1:0] flip  [D];

  always @(posedge clk) begin
    if (wrbar_a) mem_a[addr_a] <= wdata_a;
    rdata_a <= mem_a[addr_a] ^ (wrbar_a ? 32'h0 : flip[addr_a]);
    if (wrbar_b) mem_b[addr_b] <= wdata_b;
    rdata_b <= mem_b[addr_b];
  end

  // Reference pattern straight from the LFSR rule.
  logic [W-1:0] pat [D];

  function automatic int count_faults();
    int n = 0;
    for (int k = 0; k < D; k++) if (flip[k] != 0) n++;
    return n;
  endfunction

  function automatic logic [A-1:0] lowest_fault();
    for (int k = 0; k < D; k++) if (flip[k] != 0) return A'(k);
    return '0;
  endfunction

  // Behavioural model: run position as a cycle index since the start-sampling edge.
  bit          m_act;
  int          m_c;
  bit          m_pass;
  logic [A:0]  m_err;
  logic [A-1:0] m_ffa;

  always @(posedge clk) begin
    if (rst) begin
      m_act <= 0; m_c <= 0; m_pass <= 0; m_err <= '0; m_ffa <= '0;
    end else if (!m_act) begin
      if (start_a) begin
        m_act  <= 1;
        m_c    <= 0;
        m_pass <= 0;
        m_err  <= (A+1)'(count_faults());
        if (count_faults() != 0) m_ffa <= lowest_fault();
      end
    end else if (m_c == 2*D + L) begin
      m_act  <= 0;
      m_pass <= (m_err == 0);
    end else begin
      m_c <= m_c + 1;
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    logic         ew, edn;
    logic [A-1:0] ea;
    logic [W-1:0] ed;
    if (chk_en) begin
      ew = 0; edn = 0; ea = '0; ed = '0;
      if (m_act) begin
        if (m_c < D) begin
          ew = 1; ea = A'(m_c); ed = pat[m_c];
        end else if (m_c < 2*D) begin
          ea = A'(m_c - D);
        end
        edn = (m_c == 2*D + L);
      end
      check("busy", busy_a, m_act);
      check("wrbar", wrbar_a, ew);
      check("addr", addr_a, ea);
      check("wdata", wdata_a, ed);
      check("done", done_a, edn);
      check("pass", pass_a, m_pass);
      if (!m_act || edn) begin
        check("err_count", err_a, m_err);
        if (m_err != 0) check("first_fail_addr", ffa_a, m_ffa);
      end
    end
  end

  // Write-stream capture for literal checks.
  logic [W-1:0] wlog [D];
  int           n_wr = 0;
  int           rb   = 0;
  logic [W-1:0] strm [2][D];

  always @(negedge clk) begin
    if (wrbar_a) begin
      wlog[addr_a] <= wdata_a;
      n_wr <= n_wr + 1;
    end
    if (wrbar_b) strm[rb][addr_b] <= wdata_b;
  end

  task automatic clear_flips();
    for (int k = 0; k < D; k++) flip[k] = '0;
  endtask

  // One run on the main DUT; returns edges from start-sample to the edge capturing done.
  task automatic run_a(input bit s40, input bit sdone, input bit srnd,
                       output int edges, output int nd);
    int t0, tail;
    edges = -1; nd = 0; tail = -1;
    @(negedge clk);
    start_a = 1;
    t0 = cyc;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      start_a = 0;
      if (done_a) begin
        nd++;
        if (edges < 0) edges = cyc - t0;
        if (sdone) start_a = 1;
        if (tail < 0) tail = i + 6;
      end else if (s40 && wrbar_a && addr_a == 8'h40) begin
        start_a = 1;
      end else if (srnd && busy_a && $urandom_range(0, 15) == 0) begin
        start_a = 1;
      end
      if (tail >= 0 && i >= tail) break;
    end
    start_a = 0;
    if (nd == 0) check("run_timeout", 0, 1);
  endtask

  int edges, nd, diffs, found;

  initial begin
    logic [W-1:0] v;
    rst = 1; start_a = 0; start_b = 0;
    clear_flips();
    v = 32'h1;
    for (int k = 0; k < D; k++) begin
      pat[k] = v;
      v = {v[30:0], 1'b0} ^ (v[31] ? POLY : 32'h0);
    end
    check("pat0", pat[0], 32'h1);
    check("pat31", pat[31], 32'h80000000);
    check("pat32", pat[32], 32'h80200003);

    repeat (3) @(negedge clk);
    chk_en = 1;
    check("rst_busy", busy_a, 0);
    check("rst_addr", addr_a, 0);
    check("rst_wrbar", wrbar_a, 0);
    check("rst_wdata", wdata_a, 0);
    check("rst_pass", pass_a, 0);
    check("rst_err", err_a, 0);
    check("rst_ffa", ffa_a, 0);
    rst = 0;

    // Clean memory
    n_wr = 0;
    run_a(0, 0, 0, edges, nd);
    check("t1_done_edges", edges, 514);
    check("t1_ndone", nd, 1);
    check("t1_pass", pass_a, 1);
    check("t1_err", err_a, 0);
    check("t1_nwrites", n_wr, 256);
    check("t1_wdata0", wlog[0], 32'h1);
    check("t1_wdata1", wlog[1], 32'h2);
    check("t1_wdata31", wlog[31], 32'h80000000);
    check("t1_wdata32", wlog[32], 32'h80200003);

    // Single fault
    flip[8'h3A] = 32'h1;
    run_a(0, 0, 0, edges, nd);
    check("t2_err", err_a, 1);
    check("t2_ffa", ffa_a, 8'h3A);
    check("t2_pass", pass_a, 0);

    // Two faults
    clear_flips();
    flip[8'h10] = 32'h1 << $urandom_range(0, 31);
    flip[8'hF0] = 32'h1 << $urandom_range(0, 31);
    run_a(0, 0, 0, edges, nd);
    check("t3_err", err_a, 2);
    check("t3_ffa", ffa_a, 8'h10);
    check("t3_pass", pass_a, 0);

    // Start re-pulsed mid-write and in DONE
    clear_flips();
    run_a(1, 1, 0, edges, nd);
    check("t4_done_edges", edges, 514);
    check("t4_ndone", nd, 1);
    check("t4_pass", pass_a, 1);

    // Reset mid-read
    @(negedge clk);
    start_a = 1;
    @(negedge clk);
    start_a = 0;
    found = 0;
    for (int i = 0; i < 1500; i++) begin
      if (busy_a && !wrbar_a && addr_a == 8'h80) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check("t5_reached_read80", found, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("t5_busy", busy_a, 0);
    check("t5_wrbar", wrbar_a, 0);
    check("t5_addr", addr_a, 0);
    check("t5_err", err_a, 0);
    check("t5_pass", pass_a, 0);
    run_a(0, 0, 0, edges, nd);
    check("t5_rerun_pass", pass_a, 1);

    // Randomized fault sets, idle gaps and spurious starts
    for (int r = 0; r < 5; r++) begin
      clear_flips();
      for (int f = $urandom_range(0, 4); f > 0; f--)
        flip[$urandom_range(0, D-1)] = 32'h1 << $urandom_range(0, 31);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      run_a(0, 0, 1, edges, nd);
      check("rnd_done_edges", edges, 514);
      check("rnd_ndone", nd, 1);
      check("rnd_pass", pass_a, count_faults() == 0);
    end

    // Zero seed, two back-to-back runs
    for (int r = 0; r < 2; r++) begin
      rb = r;
      @(negedge clk);
      start_b = 1;
      @(negedge clk);
      start_b = 0;
      found = 0;
      for (int i = 0; i < 1500; i++) begin
        @(negedge clk);
        if (done_b) begin
          found = 1;
          break;
        end
      end
      check("t6_done_seen", found, 1);
      @(negedge clk);
      check("t6_pass", pass_b, 1);
      check("t6_err", err_b, 0);
    end
    check("t6_first_wdata", strm[0][0], 32'h1);
    diffs = 0;
    for (int k = 0; k < D; k++) if (strm[0][k] !== strm[1][k] || strm[0][k] !== pat[k]) diffs++;
    check("t6_stream_diffs", diffs, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
